// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/register_word.sv
// One storage word of the register file: an enabled register with
// asynchronous active-high clear.
module register_word
   import regfile_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Clear on reset, otherwise capture the data when enabled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// Register file: 2**ADDR_W words, one write port, two combinational read
// ports. R0 is hardwired to zero and has no storage.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a pending
// write (WE=1, Rst=0, WAddr!=0) is forwarded to any read port addressing
// the same register before the clock edge. When undefined, a read of the
// register being written returns the old value until the edge.
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WAddr,
   input  logic [DATA_W-1:0] WData,
   input  logic [ADDR_W-1:0] RAddrA,
   input  logic [ADDR_W-1:0] RAddrB,
   output logic [DATA_W-1:0] RDataA,
   output logic [DATA_W-1:0] RDataB
);

   localparam int N_REGS = 2 ** ADDR_W;

   logic [N_REGS-1:0]             w_wr_en;
   logic [N_REGS-1:0][DATA_W-1:0] w_regs;
   logic [DATA_W-1:0]             w_rdata_a;
   logic [DATA_W-1:0]             w_rdata_b;

   // One-hot write decode; R0 never gets an enable and reset blocks writes.
   always_comb begin
      w_wr_en = '0;
      for (int i = 1; i < N_REGS; i++) begin
         w_wr_en[i] = WE && !Rst && (WAddr == ADDR_W'(i));
      end
   end

   // R0 reads as constant zero.
   assign w_regs[0] = '0;

   // Storage for R1..R(N-1).
   for (genvar g = 1; g < N_REGS; g++) begin : g_word
      register_word #(
         .W (DATA_W)
      ) u_word (
         .i_clk (Clk),
         .i_rst (Rst),
         .i_en  (w_wr_en[g]),
         .i_d   (WData),
         .o_q   (w_regs[g])
      );
   end

   // Read port A mux, with optional forwarding of the pending write.
   always_comb begin
      w_rdata_a = w_regs[RAddrA];
`ifdef REGFILE_BYPASS_EN
      if (WE && !Rst && (WAddr != '0) && (WAddr == RAddrA)) begin
         w_rdata_a = WData;
      end
`endif
   end

   // Read port B mux, with optional forwarding of the pending write.
   always_comb begin
      w_rdata_b = w_regs[RAddrB];
`ifdef REGFILE_BYPASS_EN
      if (WE && !Rst && (WAddr != '0) && (WAddr == RAddrB)) begin
         w_rdata_b = WData;
      end
`endif
   end

   assign RDataA = w_rdata_a;
   assign RDataB = w_rdata_b;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reset checks, a vector table,
// hand-written multi-cycle corner cases and a randomized run against an
// array model. Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file;
   import regfile_pkg::*;

   logic      Clk;
   logic      Rst;
   logic      WE;
   reg_addr_t WAddr;
   reg_data_t WData;
   reg_addr_t RAddrA;
   reg_addr_t RAddrB;
   reg_data_t RDataA;
   reg_data_t RDataB;

   int n_tests;
   int n_fail;

   // Reference contents; index 0 is never consulted.
   reg_data_t model [NUM_REGS];

   register_file #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .WE     (WE),
      .WAddr  (WAddr),
      .WData  (WData),
      .RAddrA (RAddrA),
      .RAddrB (RAddrB),
      .RDataA (RDataA),
      .RDataB (RDataB)
   );

   // Clock: 10 ns period, rising edges at 5, 15, 25 ...
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
      end
   endtask

   // Expected read value from the architectural rules.
   function automatic reg_data_t exp_read(input reg_addr_t ra);
      reg_data_t v;
      if (Rst || ra == 0) return '0;
      v = model[ra];
`ifdef REGFILE_BYPASS_EN
      if (WE && WAddr != 0 && WAddr == ra) v = WData;
`endif
      return v;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Rst = 1'b1;
      WE  = 1'b0;
      clear_model();
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   // Single write, driven on the falling edge and committed on the rising edge.
   task automatic write_reg(input reg_addr_t a, input reg_data_t d);
      @(negedge Clk);
      WE    = 1'b1;
      WAddr = a;
      WData = d;
      @(posedge Clk);
      #1;
      if (a != 0) model[a] = d;
      @(negedge Clk);
      WE = 1'b0;
   endtask

   typedef struct {
      logic      we;
      reg_addr_t waddr;
      reg_data_t wdata;
      reg_addr_t ra;
      reg_addr_t rb;
      reg_data_t exp_a;
      reg_data_t exp_b;
   } vec_t;

   vec_t vecs [7];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      Rst     = 1'b1;
      WE      = 1'b0;
      WAddr   = '0;
      WData   = '0;
      RAddrA  = '0;
      RAddrB  = '0;
      clear_model();

      // Values after each edge; starts from a freshly reset file.
      vecs[0] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'h0000};
      vecs[1] = '{1'b1, 3'd5, 16'hBEEF, 3'd3, 3'd5, 16'h1234, 16'hBEEF};
      vecs[2] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 16'h0000, 16'h0000};
      vecs[3] = '{1'b0, 3'd3, 16'hDEAD, 3'd3, 3'd3, 16'h1234, 16'h1234};
      vecs[4] = '{1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd0, 16'hA5A5, 16'h0000};
      vecs[5] = '{1'b1, 3'd1, 16'h0F0F, 3'd1, 3'd7, 16'h0F0F, 16'hA5A5};
      vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd1, 16'hBEEF, 16'h0F0F};

      // ---- Reset: all reads zero during and after reset ----
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      for (int a = 0; a < NUM_REGS; a++) begin
         RAddrA = reg_addr_t'(a);
         RAddrB = reg_addr_t'(NUM_REGS - 1 - a);
         #1;
         check("in_reset_a", RDataA, 16'h0000);
         check("in_reset_b", RDataB, 16'h0000);
      end
      @(negedge Clk);
      Rst = 1'b0;
      for (int a = 0; a < NUM_REGS; a++) begin
         RAddrA = reg_addr_t'(a);
         RAddrB = reg_addr_t'(a);
         #1;
         check("post_reset_a", RDataA, 16'h0000);
         check("post_reset_b", RDataB, 16'h0000);
      end

      // ---- Vector table ----
      for (int i = 0; i < 7; i++) begin
         @(negedge Clk);
         WE     = vecs[i].we;
         WAddr  = vecs[i].waddr;
         WData  = vecs[i].wdata;
         RAddrA = vecs[i].ra;
         RAddrB = vecs[i].rb;
         @(posedge Clk);
         #1;
         check($sformatf("vec%0d_a", i), RDataA, vecs[i].exp_a);
         check($sformatf("vec%0d_b", i), RDataB, vecs[i].exp_b);
      end
      @(negedge Clk);
      WE = 1'b0;

      // ---- Read during write on R2, and R0 never forwarded ----
      do_reset();
      write_reg(3'd2, 16'h0001);
      @(negedge Clk);
      WE     = 1'b1;
      WAddr  = 3'd2;
      WData  = 16'h00AA;
      RAddrA = 3'd2;
      RAddrB = 3'd0;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("rdw_before_edge", RDataA, 16'h00AA);
`else
      check("rdw_before_edge", RDataA, 16'h0001);
`endif
      @(posedge Clk);
      #1;
      check("rdw_after_edge", RDataA, 16'h00AA);
      @(negedge Clk);
      WAddr  = 3'd0;
      WData  = 16'h1234;
      RAddrA = 3'd0;
      #1;
      check("r0_no_bypass_a", RDataA, 16'h0000);
      check("r0_no_bypass_b", RDataB, 16'h0000);
      @(negedge Clk);
      WE = 1'b0;

      // ---- Reset mid-cycle during a write to R4 ----
      write_reg(3'd4, 16'h5555);
      RAddrA = 3'd4;
      RAddrB = 3'd4;
      #1;
      check("r4_written", RDataA, 16'h5555);
      @(negedge Clk);
      WE    = 1'b1;
      WAddr = 3'd4;
      WData = 16'h7777;
      #2;
      Rst = 1'b1;
      #1;
      check("rst_mid_a", RDataA, 16'h0000);
      check("rst_mid_b", RDataB, 16'h0000);
      @(posedge Clk);
      #1;
      check("rst_edge_a", RDataA, 16'h0000);
      check("rst_edge_b", RDataB, 16'h0000);
      // First edge after release writes normally.
      @(negedge Clk);
      Rst   = 1'b0;
      WData = 16'h1357;
      clear_model();
      @(posedge Clk);
      #1;
      check("first_write_after_rst", RDataA, 16'h1357);
      @(negedge Clk);
      WE = 1'b0;
      #1;
      check("first_write_held", RDataB, 16'h1357);

      // ---- Randomized run against the array model ----
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         @(negedge Clk);
         Rst    = ($urandom_range(0, 49) == 0);
         WE     = $urandom_range(0, 1);
         WAddr  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         WData  = reg_data_t'($urandom);
         RAddrA = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         RAddrB = ($urandom_range(0, 3) == 0) ? WAddr
                                              : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
         if (Rst) clear_model();
         #1;
         check("rand_pre_a", RDataA, exp_read(RAddrA));
         check("rand_pre_b", RDataB, exp_read(RAddrB));
         @(posedge Clk);
         if (!Rst && WE && WAddr != 0) model[WAddr] = WData;
         #1;
         check("rand_post_a", RDataA, exp_read(RAddrA));
         check("rand_post_b", RDataB, exp_read(RAddrB));
      end
      @(negedge Clk);
      Rst = 1'b0;
      WE  = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
